// File: rtl/oled_init_sequencer_if.sv
// Byte link between the OLED init sequencer, the SPI byte controller and the host.
// master = sequencer side, slave = SPI controller / host side.
interface oled_init_sequencer_if;
   logic       spi_load;
   logic       spi_done;
   logic [7:0] spi_byte;
   logic       oled_dc;
   logic       host_valid;
   logic       host_dc;
   logic [7:0] host_data;
   logic       host_ready;

   modport master (
      output spi_load, spi_byte, oled_dc, host_ready,
      input  spi_done, host_valid, host_dc, host_data
   );

   modport slave (
      input  spi_load, spi_byte, oled_dc, host_ready,
      output spi_done, host_valid, host_dc, host_data
   );
endinterface

// File: rtl/oled_init_sequencer.sv
// SSD1306 power-up/command sequencer feeding the SPI byte controller, then host byte arbitration.
// Optional GDDRAM clear pass after init is built when OLED_CLEAR_EN is defined.
//
// state    | meaning
// S_SYNC   | wait for spi_done low
// S_VDD    | logic rail on, wait VDD_DLY
// S_CMD_A  | send 0xAE (display off)
// S_RST_LO | res_n low for RST_DLY
// S_RST_HI | res_n high, settle RST_DLY
// S_CMD_B  | send charge-pump / precharge commands
// S_VBAT   | panel rail on, wait VBAT_DLY
// S_CMD_C  | send contrast/remap/addressing commands, display on
// S_CLEAR  | write CLEAR_BYTES zero data bytes (OLED_CLEAR_EN only)
// S_READY  | init done, forward host bytes
module oled_init_sequencer #(
   parameter int unsigned VDD_DLY     = 100_000,
   parameter int unsigned RST_DLY     = 1_000,
   parameter int unsigned VBAT_DLY    = 10_000_000,
   parameter int unsigned CLEAR_BYTES = 512
) (
   input  logic                      clk,
   input  logic                      reset,
   oled_init_sequencer_if.master     bus,
   output logic                      oled_res_n,
   output logic                      oled_vdd_n,
   output logic                      oled_vbat_n,
   output logic                      init_done
);

   if (VDD_DLY < 1 || VDD_DLY > 24'hFF_FFFF || RST_DLY < 1 || RST_DLY > 24'hFF_FFFF ||
       VBAT_DLY < 1 || VBAT_DLY > 24'hFF_FFFF || CLEAR_BYTES < 1 || CLEAR_BYTES > 1024) begin : g_bad_param
      $error("oled_init_sequencer: parameter out of range");
   end

   typedef enum logic [3:0] {
      S_SYNC, S_VDD, S_CMD_A, S_RST_LO, S_RST_HI, S_CMD_B, S_VBAT, S_CMD_C, S_CLEAR, S_READY
   } state_t;

   typedef enum logic [1:0] {PH_IDLE, PH_REQ, PH_ACK} phase_t;

   localparam logic [23:0] VDD_LD  = 24'(VDD_DLY - 1);
   localparam logic [23:0] RST_LD  = 24'(RST_DLY - 1);
   localparam logic [23:0] VBAT_LD = 24'(VBAT_DLY - 1);
   localparam logic [3:0]  PTR_B_LAST = 4'd4;
   localparam logic [3:0]  PTR_C_LAST = 4'd13;

   function automatic logic [7:0] init_rom(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'hAE;
         4'd1:    b = 8'h8D;
         4'd2:    b = 8'h14;
         4'd3:    b = 8'hD9;
         4'd4:    b = 8'hF1;
         4'd5:    b = 8'h81;
         4'd6:    b = 8'h0F;
         4'd7:    b = 8'hA0;
         4'd8:    b = 8'hC0;
         4'd9:    b = 8'hDA;
         4'd10:   b = 8'h00;
         4'd11:   b = 8'h20;
         4'd12:   b = 8'h00;
         4'd13:   b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [23:0] cnt_q, cnt_d;
   logic        spi_load_q, spi_load_d;
   logic [7:0]  spi_byte_q, spi_byte_d;
   logic        oled_dc_q, oled_dc_d;
   logic        res_n_q, res_n_d;
   logic        vdd_n_q, vdd_n_d;
   logic        vbat_n_q, vbat_n_d;
   logic        init_done_q, init_done_d;
   logic        host_ready_q, host_ready_d;
   logic        byte_done;
   logic        start_rom;
   logic        enter_ready;
`ifdef OLED_CLEAR_EN
   localparam logic [9:0] CLR_LAST = 10'(CLEAR_BYTES - 1);
   logic [9:0]  clr_q, clr_d;
   logic        start_clr;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_SYNC;
         phase_q      <= PH_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         spi_load_q   <= 1'b0;
         spi_byte_q   <= 8'h00;
         oled_dc_q    <= 1'b0;
         res_n_q      <= 1'b1;
         vdd_n_q      <= 1'b1;
         vbat_n_q     <= 1'b1;
         init_done_q  <= 1'b0;
         host_ready_q <= 1'b0;
`ifdef OLED_CLEAR_EN
         clr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         spi_load_q   <= spi_load_d;
         spi_byte_q   <= spi_byte_d;
         oled_dc_q    <= oled_dc_d;
         res_n_q      <= res_n_d;
         vdd_n_q      <= vdd_n_d;
         vbat_n_q     <= vbat_n_d;
         init_done_q  <= init_done_d;
         host_ready_q <= host_ready_d;
`ifdef OLED_CLEAR_EN
         clr_q        <= clr_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      spi_load_d   = spi_load_q;
      spi_byte_d   = spi_byte_q;
      oled_dc_d    = oled_dc_q;
      res_n_d      = res_n_q;
      vdd_n_d      = vdd_n_q;
      vbat_n_d     = vbat_n_q;
      init_done_d  = init_done_q;
      host_ready_d = host_ready_q;
      byte_done    = 1'b0;
      start_rom    = 1'b0;
      enter_ready  = 1'b0;
`ifdef OLED_CLEAR_EN
      clr_d        = clr_q;
      start_clr    = 1'b0;
`endif

      // Shared REQ/ACK handshake; each state only decides what follows a completed byte.
      if (phase_q == PH_REQ && bus.spi_done) begin
         phase_d    = PH_ACK;
         spi_load_d = 1'b0;
      end
      if (phase_q == PH_ACK && !bus.spi_done) begin
         byte_done = 1'b1;
      end

      case (state_q)
         S_SYNC: begin
            if (!bus.spi_done) begin
               state_d = S_VDD;
               cnt_d   = VDD_LD;
               vdd_n_d = 1'b0;
            end
         end
         S_VDD: begin
            if (cnt_q == 24'd0) begin
               state_d   = S_CMD_A;
               start_rom = 1'b1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_CMD_A: begin
            if (byte_done) begin
               ptr_d   = ptr_q + 4'd1;
               phase_d = PH_IDLE;
               state_d = S_RST_LO;
               cnt_d   = RST_LD;
               res_n_d = 1'b0;
            end
         end
         S_RST_LO: begin
            if (cnt_q == 24'd0) begin
               state_d = S_RST_HI;
               cnt_d   = RST_LD;
               res_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_RST_HI: begin
            if (cnt_q == 24'd0) begin
               state_d   = S_CMD_B;
               start_rom = 1'b1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_CMD_B: begin
            if (byte_done) begin
               ptr_d = ptr_q + 4'd1;
               if (ptr_q == PTR_B_LAST) begin
                  phase_d  = PH_IDLE;
                  state_d  = S_VBAT;
                  cnt_d    = VBAT_LD;
                  vbat_n_d = 1'b0;
               end else begin
                  start_rom = 1'b1;
               end
            end
         end
         S_VBAT: begin
            if (cnt_q == 24'd0) begin
               state_d   = S_CMD_C;
               start_rom = 1'b1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_CMD_C: begin
            if (byte_done) begin
               ptr_d = ptr_q + 4'd1;
               if (ptr_q == PTR_C_LAST) begin
`ifdef OLED_CLEAR_EN
                  state_d   = S_CLEAR;
                  clr_d     = '0;
                  start_clr = 1'b1;
`else
                  enter_ready = 1'b1;
`endif
               end else begin
                  start_rom = 1'b1;
               end
            end
         end
`ifdef OLED_CLEAR_EN
         S_CLEAR: begin
            if (byte_done) begin
               if (clr_q == CLR_LAST) begin
                  enter_ready = 1'b1;
               end else begin
                  clr_d     = clr_q + 10'd1;
                  start_clr = 1'b1;
               end
            end
         end
`endif
         S_READY: begin
            if (phase_q == PH_IDLE) begin
               if (bus.host_valid && host_ready_q) begin
                  phase_d      = PH_REQ;
                  spi_load_d   = 1'b1;
                  spi_byte_d   = bus.host_data;
                  oled_dc_d    = bus.host_dc;
                  host_ready_d = 1'b0;
               end
            end else if (byte_done) begin
               phase_d      = PH_IDLE;
               host_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_SYNC;
            phase_d = PH_IDLE;
         end
      endcase

      if (start_rom) begin
         phase_d    = PH_REQ;
         spi_load_d = 1'b1;
         spi_byte_d = init_rom(ptr_d);
         oled_dc_d  = 1'b0;
      end
`ifdef OLED_CLEAR_EN
      if (start_clr) begin
         phase_d    = PH_REQ;
         spi_load_d = 1'b1;
         spi_byte_d = 8'h00;
         oled_dc_d  = 1'b1;
      end
`endif
      if (enter_ready) begin
         state_d      = S_READY;
         phase_d      = PH_IDLE;
         init_done_d  = 1'b1;
         host_ready_d = 1'b1;
      end
   end

   assign bus.spi_load   = spi_load_q;
   assign bus.spi_byte   = spi_byte_q;
   assign bus.oled_dc    = oled_dc_q;
   assign bus.host_ready = host_ready_q;
   assign oled_res_n     = res_n_q;
   assign oled_vdd_n     = vdd_n_q;
   assign oled_vbat_n    = vbat_n_q;
   assign init_done      = init_done_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer: behavioural SPI controller, byte capture and timing checks.
// Honours OLED_CLEAR_EN to expect the zero-fill pass.
module tb_oled_init_sequencer;
   localparam int VDD_DLY     = 10;
   localparam int RST_DLY     = 4;
   localparam int VBAT_DLY    = 20;
   localparam int CLEAR_BYTES = 512;
`ifdef OLED_CLEAR_EN
   localparam int N_CLR = CLEAR_BYTES;
`else
   localparam int N_CLR = 0;
`endif
   localparam int N_INIT = 14 + N_CLR;
   localparam int N_HOST = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic oled_res_n, oled_vdd_n, oled_vbat_n, init_done;

   oled_init_sequencer_if bus();

   oled_init_sequencer #(
      .VDD_DLY(VDD_DLY), .RST_DLY(RST_DLY), .VBAT_DLY(VBAT_DLY), .CLEAR_BYTES(CLEAR_BYTES)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .oled_res_n(oled_res_n), .oled_vdd_n(oled_vdd_n),
      .oled_vbat_n(oled_vbat_n), .init_done(init_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SPI controller model: done rises 8 cycles after load, falls 2 cycles after load drops
   int ld_cnt, fall_cnt;
   always @(posedge clk) begin
      if (reset) begin
         bus.spi_done <= 1'b0;
         ld_cnt       <= 0;
         fall_cnt     <= 0;
      end else if (bus.spi_load && !bus.spi_done) begin
         fall_cnt <= 0;
         if (ld_cnt == 7) begin
            bus.spi_done <= 1'b1;
            ld_cnt       <= 0;
         end else begin
            ld_cnt <= ld_cnt + 1;
         end
      end else if (!bus.spi_load && bus.spi_done) begin
         ld_cnt <= 0;
         if (fall_cnt == 1) begin
            bus.spi_done <= 1'b0;
            fall_cnt     <= 0;
         end else begin
            fall_cnt <= fall_cnt + 1;
         end
      end
   end

   logic [8:0] cap[$];
   int rise_cyc[$];
   int fall_cyc[$];
   int vdd_fall, res_fall, res_lo_cnt, vbat_fall, idone_cyc, cap_at_done;
   int stab_err, hr_err;
   logic load_prev, done_prev;
   logic [8:0] held;

   always @(negedge clk) begin
      if (reset) begin
         cap.delete();
         rise_cyc.delete();
         fall_cyc.delete();
         vdd_fall = -1; res_fall = -1; vbat_fall = -1; idone_cyc = -1;
         res_lo_cnt = 0; cap_at_done = -1; stab_err = 0; hr_err = 0;
         load_prev = 1'b0; done_prev = 1'b0; held = '0;
      end else begin
         if (bus.spi_load && !load_prev) begin
            cap.push_back({bus.oled_dc, bus.spi_byte});
            rise_cyc.push_back(cyc);
            held = {bus.oled_dc, bus.spi_byte};
         end else if (bus.spi_load && ({bus.oled_dc, bus.spi_byte} !== held)) begin
            stab_err++;
         end
         if (!bus.spi_done && done_prev) fall_cyc.push_back(cyc);
         if (!oled_vdd_n && vdd_fall < 0) vdd_fall = cyc;
         if (!oled_res_n) begin
            res_lo_cnt++;
            if (res_fall < 0) res_fall = cyc;
         end
         if (!oled_vbat_n && vbat_fall < 0) vbat_fall = cyc;
         if (init_done && idone_cyc < 0) begin
            idone_cyc   = cyc;
            cap_at_done = cap.size();
         end
         if (bus.host_ready && !init_done) hr_err++;
         if (bus.host_ready && (bus.spi_load || bus.spi_done)) hr_err++;
         load_prev = bus.spi_load;
         done_prev = bus.spi_done;
      end
   end

   function automatic logic [8:0] cap_at(input int i);
      return (i < cap.size()) ? cap[i] : 9'h1FF;
   endfunction
   function automatic int rise_at(input int i);
      return (i < rise_cyc.size()) ? rise_cyc[i] : -1000;
   endfunction
   function automatic int fall_at(input int i);
      return (i < fall_cyc.size()) ? fall_cyc[i] : -1000;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_reset_vals(input string name);
      logic [14:0] v;
      v = {bus.spi_load, bus.spi_byte, bus.oled_dc, oled_res_n, oled_vdd_n,
           oled_vbat_n, init_done, bus.host_ready};
      chk(name, int'(v), int'(15'b0_00000000_0_111_00));
   endtask

   typedef struct {
      logic [7:0] b;
      logic       dc;
   } init_vec_t;

   typedef struct {
      logic [7:0] in_data;
      logic       in_dc;
      logic [7:0] exp_b;
      logic       exp_dc;
   } host_vec_t;

   init_vec_t init_tbl[14];
   host_vec_t host_tbl[N_HOST];

   initial begin
      int base, nf, bad;
      init_tbl = '{'{8'hAE, 1'b0}, '{8'h8D, 1'b0}, '{8'h14, 1'b0}, '{8'hD9, 1'b0},
                   '{8'hF1, 1'b0}, '{8'h81, 1'b0}, '{8'h0F, 1'b0}, '{8'hA0, 1'b0},
                   '{8'hC0, 1'b0}, '{8'hDA, 1'b0}, '{8'h00, 1'b0}, '{8'h20, 1'b0},
                   '{8'h00, 1'b0}, '{8'hAF, 1'b0}};
      host_tbl = '{'{8'h55, 1'b1, 8'h55, 1'b1}, '{8'h3C, 1'b0, 8'h3C, 1'b0},
                   '{8'hA5, 1'b1, 8'hA5, 1'b1}, '{8'hFF, 1'b0, 8'hFF, 1'b0}};

      bus.host_valid = 1'b0;
      bus.host_dc    = 1'b0;
      bus.host_data  = 8'h00;

      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_reset_vals("reset_hold");
      end

      // first power-up, interrupted by reset while waiting on VBAT
      reset = 1'b0;
      base  = cyc;
      for (int k = 0; k < 200 && cap.size() < 1; k++) tick();
      chk("vdd_fall_cycle", vdd_fall - base, 1);
      chk("vdd_to_first_load", rise_at(0) - vdd_fall, VDD_DLY);
      chk("first_byte", int'(cap_at(0)), int'({1'b0, 8'hAE}));
      for (int k = 0; k < 1000 && oled_vbat_n; k++) tick();
      chk("vbat_reached", int'(oled_vbat_n), 0);
      repeat (5) tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_reset_vals("reset_mid_vbat");
      end

      // replay with host_valid asserted throughout init
      reset          = 1'b0;
      base           = cyc;
      bus.host_valid = 1'b1;
      bus.host_data  = 8'hEE;
      bus.host_dc    = 1'b1;
      for (int k = 0; k < 20000 && cap.size() < N_INIT; k++) tick();
      bus.host_valid = 1'b0;
      for (int k = 0; k < 200 && !init_done; k++) tick();
      chk("init_done_reached", int'(init_done), 1);

      chk("replay_vdd_fall_cycle", vdd_fall - base, 1);
      chk("replay_vdd_to_first_load", rise_at(0) - vdd_fall, VDD_DLY);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("init_byte_%0d", i), int'(cap_at(i)), int'({init_tbl[i].dc, init_tbl[i].b}));
      end
      chk("res_low_cycles", res_lo_cnt, RST_DLY);
      chk("res_fall_after_ae_ack", res_fall, fall_at(0) + 1);
      chk("vbat_fall_after_f1_ack", vbat_fall, fall_at(4) + 1);
      chk("vbat_to_0x81_load", rise_at(5) - vbat_fall, VBAT_DLY);
      chk("back_to_back_req", rise_at(2), fall_at(1) + 1);
`ifdef OLED_CLEAR_EN
      bad = 0;
      for (int i = 14; i < N_INIT; i++) if (cap_at(i) !== {1'b1, 8'h00}) bad++;
      chk("clear_bytes_bad", bad, 0);
`endif
      chk("bytes_at_init_done", cap_at_done, N_INIT);
      chk("init_done_after_last_ack", idone_cyc, fall_at(N_INIT - 1) + 1);
      chk("host_ready_during_init", hr_err, 0);

      for (int i = 0; i < N_HOST; i++) begin
         for (int k = 0; k < 100 && !bus.host_ready; k++) tick();
         bus.host_valid = 1'b1;
         bus.host_data  = host_tbl[i].in_data;
         bus.host_dc    = host_tbl[i].in_dc;
         nf = fall_cyc.size();
         tick();
         bus.host_valid = 1'b0;
         chk($sformatf("host_accept_%0d", i), int'({bus.host_ready, bus.spi_load}), int'(2'b01));
         for (int k = 0; k < 100 && fall_cyc.size() == nf; k++) tick();
         tick();
         chk($sformatf("host_ready_return_%0d", i), int'(bus.host_ready), 1);
      end
      for (int i = 0; i < N_HOST; i++) begin
         chk($sformatf("host_byte_%0d", i), int'(cap_at(N_INIT + i)),
             int'({host_tbl[i].exp_dc, host_tbl[i].exp_b}));
      end
      chk("total_bytes", cap.size(), N_INIT + N_HOST);
      chk("host_ready_in_flight", hr_err, 0);
      chk("byte_stable_during_load", stab_err, 0);
      chk("init_done_level", int'(init_done), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oled_init_sequencer.md
# oled_init_sequencer

Power-up and command sequencer for the SSD1306-based OLED panel, sitting directly upstream of the SPI byte controller. Drives the panel rails (VDD, VBAT), the panel reset and D/C# lines, and feeds command/data bytes one at a time into the SPI controller's load/done handshake. After initialisation it arbitrates host byte writes onto the same SPI path.

## Interface
Parameters:
- VDD_DLY, 100_000: clk cycles to wait after VDD on (1 ms at 100 MHz).
- RST_DLY, 1_000: clk cycles res_n is held low, and the settle time after release.
- VBAT_DLY, 10_000_000: clk cycles to wait after VBAT on (100 ms). All delays 1..2^24-1.
- CLEAR_BYTES, 512: data bytes written by the clear pass (128x32/8).

Ports:
- clk  in  1  on-board clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- spi_done  in  1  done flag from the SPI controller.
- spi_load  out  1  byte request to the SPI controller.
- spi_byte  out  8  byte presented to the SPI controller.
- oled_dc  out  1  D/C#: 0 = command, 1 = display data.
- oled_res_n  out  1  panel reset, active-low.
- oled_vdd_n  out  1  logic rail enable, active-low.
- oled_vbat_n  out  1  panel rail enable, active-low.
- init_done  out  1  high once the init sequence (and clear, if built) completes.
- host_valid  in  1  host byte request.
- host_dc  in  1  D/C# for the host byte.
- host_data  in  8  host byte.
- host_ready  out  1  host byte accepted when host_valid && host_ready.

## Operation
- Reset values: spi_load=0, spi_byte=0x00, oled_dc=0, oled_res_n=1, oled_vdd_n=1, oled_vbat_n=1, init_done=0, host_ready=0. Reset at any point aborts and restarts from SYNC.
- States, in order:
  - SYNC: wait for spi_done=0.
  - VDD: oled_vdd_n=0, wait VDD_DLY.
  - CMD_A: send 0xAE.
  - RST_LO: oled_res_n=0 for RST_DLY.
  - RST_HI: oled_res_n=1, wait RST_DLY.
  - CMD_B: send 0x8D 0x14 0xD9 0xF1.
  - VBAT: oled_vbat_n=0, wait VBAT_DLY.
  - CMD_C: send 0x81 0x0F 0xA0 0xC0 0xDA 0x00 0x20 0x00 0xAF.
  - CLEAR: optional, see Configuration.
  - READY.
- Init bytes come from a 14-entry ROM indexed by a 4-bit pointer; oled_dc=0 for all of them.
- Byte send sub-machine:
  - REQ: spi_byte/oled_dc stable, spi_load=1 until spi_done=1.
  - ACK: spi_load=0 until spi_done=0.
  - Then advance.
- spi_byte and oled_dc change only while spi_load=0 and spi_done=0.
- READY:
  - init_done=1; host_ready=1 whenever no byte is in flight.
  - On accept: latch host_data/host_dc, host_ready=0, run REQ/ACK.
  - host_ready returns to 1 the cycle after spi_done is seen low.
  - host_valid is ignored while host_ready=0, including all of init.
- Rails stay on after init; nothing powers them down except reset.
- Delay counter is 24 bits, loaded with DLY-1 on state entry; the state exits on the cycle the counter reads 0.

## Timing
- VDD low: the first cycle after SYNC sees spi_done=0.
- Delay states: last exactly DLY cycles each.
- REQ exit: spi_load falls the cycle after spi_done is sampled high.
- ACK exit: the next REQ (or READY) begins the cycle after spi_done is sampled low.
- Host accept to spi_load=1: 1 cycle.
- init_done: rises the cycle after the final ACK completes. It is a level and stays high until reset.
- spi_done is sampled directly. It is generated from clk-derived logic in the SPI controller, so no synchroniser is used.

## Configuration
- OLED_CLEAR_EN defined:
  - After CMD_C, the CLEAR state sends CLEAR_BYTES bytes of 0x00 with oled_dc=1, using a 10-bit counter.
  - init_done rises only after the last clear byte's ACK.
- OLED_CLEAR_EN undefined:
  - CLEAR is omitted; CMD_C goes straight to READY.
  - GDDRAM contents are undefined.

## Test plan
Bench uses VDD_DLY=10, RST_DLY=4, VBAT_DLY=20 and a behavioural SPI model that raises done 8 cycles after load and drops it 2 cycles after load falls.
- Reset release:
  - oled_vdd_n falls on cycle 1.
  - First spi_load with spi_byte=0xAE comes 10 cycles later.
  - All outputs held at their reset values while reset=1.
- Init byte order: the captured byte stream equals AE, 8D, 14, D9, F1, 81, 0F, A0, C0, DA, 00, 20, 00, AF, all with dc=0.
- Rail and reset ordering:
  - oled_res_n low exactly 4 cycles, after 0xAE's ACK.
  - oled_vbat_n falls after 0xF1's ACK.
  - 0x81 request starts exactly 20 cycles later.
- Clear (OLED_CLEAR_EN): 512 bytes of 0x00 with dc=1 follow 0xAF; init_done rises only after the last ACK. Without the macro, init_done rises right after 0xAF.
- Host path:
  - host_valid=1 during init: no accept.
  - In READY, send 0x55/dc=1 then 0x3C/dc=0 back-to-back: model receives both in order with the correct dc.
  - host_ready low while each byte is in flight.
- Reset mid-operation: assert reset during VBAT wait. All outputs return to their reset values, and the sequence replays from VDD after release.
